// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding, oversampling ratio and TSR bit positions.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // TSR bit positions, laid out alongside the receiver's LSR indices
  localparam int TSR_FIFO_EMPTY = 0;
  localparam int TSR_OVERFLOW   = 1;
  localparam int TSR_BUSY       = 2;
  localparam int TSR_IDLE       = 3;

endpackage

// File: rtl/uart_fifo.sv
// Generic synchronous FIFO with registered pointers and a head-of-queue combinational read.
// Write is dropped when full (full sampled before any same-cycle pop); read is ignored when empty.
module uart_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 2 ** AW;
  localparam int CW    = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed, back-to-back frames with optional parity, tx registered (one clock behind FSM).
// No per-byte handshake; writes while full are dropped and latch the sticky overflow flag in TSR.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int SB_TICK    = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            b_tick,
  input  logic            wr_en,
  input  logic [DBIT-1:0] wr_data,
  input  logic            clear_flags,
  output logic            tx,
  output logic            tx_done_tick,
  output logic            fifo_full,
  output logic [3:0]      TSR
);

  localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  tx_state_t       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            p_q, p_d;
  logic            tx_q, tx_d;
  logic            done_q;
  logic            ovf_q;
  logic            pop;
  logic            stop_end;
  logic            bit_end;
  logic            fifo_empty;
  logic [DBIT-1:0] fifo_head;

  uart_fifo #(.DW(DBIT), .AW(FIFO_AW)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bit_end = b_tick && (s_q == SW'(OVERSAMPLE - 1));

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    n_d      = n_q;
    b_d      = b_q;
    p_d      = p_q;
    tx_d     = 1'b1;
    pop      = 1'b0;
    stop_end = 1'b0;
    case (state_q)
      IDLE: begin
        pop = !fifo_empty;
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          s_d     = '0;
          n_d     = '0;
          state_d = DATA;
        end else if (b_tick) begin
          s_d = s_q + SW'(1);
        end
      end
      DATA: begin
        tx_d = b_q[0];
        if (bit_end) begin
          s_d = '0;
          b_d = b_q >> 1;
          if (n_q == NW'(DBIT - 1)) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            n_d = n_q + NW'(1);
          end
        end else if (b_tick) begin
          s_d = s_q + SW'(1);
        end
      end
      PARITY: begin
        tx_d = p_q;
        if (bit_end) begin
          s_d     = '0;
          state_d = STOP;
        end else if (b_tick) begin
          s_d = s_q + SW'(1);
        end
      end
      STOP: begin
        if (b_tick && (s_q == SW'(SB_TICK - 1))) begin
          stop_end = 1'b1;
          s_d      = '0;
          state_d  = IDLE;
          pop      = !fifo_empty;
        end else if (b_tick) begin
          s_d = s_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Loading a new byte is shared by the IDLE start and the back-to-back STOP restart
    if (pop) begin
      b_d     = fifo_head;
      p_d     = (^fifo_head) ^ 1'(PARITY_ODD);
      s_d     = '0;
      state_d = START;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      p_q     <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      p_q     <= p_d;
      tx_q    <= tx_d;
      done_q  <= stop_end;
      if (wr_en && fifo_full) begin
        ovf_q <= 1'b1;
      end else if (clear_flags) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign tx           = tx_q;
  assign tx_done_tick = done_q;

  assign TSR[TSR_FIFO_EMPTY] = fifo_empty;
  assign TSR[TSR_OVERFLOW]   = ovf_q;
  assign TSR[TSR_BUSY]       = (state_q != IDLE);
  assign TSR[TSR_IDLE]       = (state_q == IDLE) && fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (16-tick stop/even, 32-tick stop/odd) against a frame-position model.
module tb_uart_tx_fifo;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       b_tick = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clear_flags = 1'b0;

  logic       tx_a, done_a, full_a;
  logic [3:0] tsr_a;
  logic       tx_b, done_b, full_b;
  logic [3:0] tsr_b;

  int checks = 0;
  int passed = 0;
  int tick_mode = 0;

  uart_tx_fifo dut_a (
    .clock(clock), .reset(reset), .b_tick(b_tick), .wr_en(wr_en), .wr_data(wr_data),
    .clear_flags(clear_flags), .tx(tx_a), .tx_done_tick(done_a), .fifo_full(full_a), .TSR(tsr_a)
  );

  uart_tx_fifo #(.SB_TICK(32), .PARITY_ODD(1)) dut_b (
    .clock(clock), .reset(reset), .b_tick(b_tick), .wr_en(wr_en), .wr_data(wr_data),
    .clear_flags(clear_flags), .tx(tx_b), .tx_done_tick(done_b), .fifo_full(full_b), .TSR(tsr_b)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic cyc();
    @(negedge clock);
    #2;
  endtask

  // b_tick source: period 4 (directed) or random (~1 in 3)
  initial begin
    int tc;
    tc = 0;
    forever begin
      @(negedge clock);
      if (tick_mode == 0) begin
        b_tick = (tc == 3);
        tc = (tc + 1) % 4;
      end else begin
        b_tick = ($urandom_range(2) == 0);
      end
    end
  end

  // Reference model: FIFO contents plus position (in b_ticks) within the current frame
  logic [7:0] mbuf [2][16];
  logic [7:0] mcur [2];
  int  mhead [2];
  int  mcnt [2];
  int  mpos [2];
  bit  mact [2];
  bit  movf [2];
  bit  etx [2];
  bit  edone [2];

  function automatic int flen(input int k);
    return 10 * 16 + ((k == 0) ? 16 : 32);
  endfunction

  function automatic bit mline(input int k);
    int p;
    p = mpos[k];
    if (!mact[k]) return 1'b1;
    if (p < 16) return 1'b0;
    if (p < 144) return mcur[k][(p - 16) / 16];
    if (p < 160) return (^mcur[k]) ^ (k == 1);
    return 1'b1;
  endfunction

  function automatic int exp_tsr(input int k);
    return {28'd0, (!mact[k] && mcnt[k] == 0), mact[k], movf[k], (mcnt[k] == 0)};
  endfunction

  initial begin
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        for (int k = 0; k < 2; k++) begin
          mhead[k] = 0; mcnt[k] = 0; mpos[k] = 0; mact[k] = 0;
          movf[k] = 0; etx[k] = 1; edone[k] = 0; mcur[k] = 8'h00;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          int  sz;
          bit  pop;
          sz = mcnt[k];
          pop = 0;
          etx[k] = mline(k);
          edone[k] = 0;
          if (!mact[k]) begin
            pop = (sz > 0);
          end else if (b_tick) begin
            if (mpos[k] == flen(k) - 1) begin
              edone[k] = 1;
              if (sz > 0) pop = 1;
              else mact[k] = 0;
            end else begin
              mpos[k]++;
            end
          end
          if (pop) begin
            mcur[k] = mbuf[k][mhead[k]];
            mhead[k] = (mhead[k] + 1) % 16;
            mcnt[k]--;
            mact[k] = 1;
            mpos[k] = 0;
          end
          if (wr_en && sz == 16) begin
            movf[k] = 1;
          end else begin
            if (wr_en) begin
              mbuf[k][(mhead[k] + mcnt[k]) % 16] = wr_data;
              mcnt[k]++;
            end
            if (clear_flags) movf[k] = 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (reset) begin
        check("tx_a", int'(tx_a), int'(etx[0]));
        check("done_a", int'(done_a), int'(edone[0]));
        check("full_a", int'(full_a), int'(mcnt[0] == 16));
        check("tsr_a", int'(tsr_a), exp_tsr(0));
        check("tx_b", int'(tx_b), int'(etx[1]));
        check("done_b", int'(done_b), int'(edone[1]));
        check("full_b", int'(full_b), int'(mcnt[1] == 16));
        check("tsr_b", int'(tsr_b), exp_tsr(1));
      end
    end
  end

  // Line monitor: ticks since first falling edge, mid-bit samples, done counts
  bit          mon_arm = 0;
  int          ta, tb, la, lb, da, db, bi, mc, fall_cyc;
  logic [10:0] got;

  task automatic arm();
    ta = -1; tb = -1; la = -1; lb = -1; da = 0; db = 0;
    bi = 0; mc = 0; fall_cyc = -1; got = '0; mon_arm = 1;
  endtask

  initial begin
    forever begin
      @(negedge clock);
      #3;
      if (mon_arm) begin
        if (ta < 0 && !tx_a) begin ta = 0; fall_cyc = mc; end
        if (tb < 0 && !tx_b) tb = 0;
        if (done_a) begin da++; la = ta; end
        if (done_b) begin db++; lb = tb; end
        if (b_tick) begin
          if (ta >= 0) begin
            ta++;
            if (bi < 11 && ta == 16 * bi + 8) begin got[bi] = tx_a; bi++; end
          end
          if (tb >= 0) tb++;
        end
        mc++;
      end
    end
  end

  task automatic align_tick();
    for (int i = 0; i < 8 && !b_tick; i++) cyc();
  endtask

  task automatic wait_idle(input int maxc, output bit to);
    to = 1;
    for (int i = 0; i < maxc; i++) begin
      cyc();
      if (tsr_a == 4'b1001 && tsr_b == 4'b1001) begin to = 0; break; end
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    bit         to;
    int         low;
    logic [7:0] burst [4];

    repeat (3) cyc();
    check("rst_tx_a", int'(tx_a), 1);
    check("rst_done_a", int'(done_a), 0);
    check("rst_full_a", int'(full_a), 0);
    check("rst_tsr_a", int'(tsr_a), 9);
    check("rst_tx_b", int'(tx_b), 1);
    check("rst_tsr_b", int'(tsr_b), 9);
    reset = 1'b1;
    repeat (5) cyc();

    // Single 0xA5 frame
    align_tick();
    arm();
    wr_en = 1'b1; wr_data = 8'hA5;
    cyc();
    wr_en = 1'b0;
    wait_idle(4000, to);
    cyc();
    check("t1_timeout", int'(to), 0);
    check("t1_latency", fall_cyc, 3);
    check("t1_bits", int'(got), 11'b10101001010);
    check("t1_dones_a", da, 1);
    check("t1_ticks_a", la, 176);
    check("t1_dones_b", db, 1);
    check("t1_ticks_b", lb, 192);
    check("t1_tsr_a", int'(tsr_a), 9);

    // Back-to-back burst
    burst = '{8'h00, 8'hFF, 8'h55, 8'h81};
    align_tick();
    arm();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = burst[i];
      cyc();
    end
    wr_en = 1'b0;
    wait_idle(8000, to);
    cyc();
    check("t2_timeout", int'(to), 0);
    check("t2_bits", int'(got), 11'b10000000000);
    check("t2_dones_a", da, 4);
    check("t2_ticks_a", la, 704);
    check("t2_dones_b", db, 4);
    check("t2_ticks_b", lb, 768);

    // Overflow: 18 back-to-back writes while the first byte is already popped
    align_tick();
    for (int k = 1; k <= 18; k++) begin
      wr_en = 1'b1; wr_data = 8'(k);
      cyc();
      if (k == 16) check("t3_full_at16", int'(full_a), 0);
      if (k == 17) begin
        check("t3_full_at17", int'(full_a), 1);
        check("t3_ovf_at17", int'(tsr_a[1]), 0);
      end
      if (k == 18) begin
        check("t3_ovf_a", int'(tsr_a[1]), 1);
        check("t3_ovf_b", int'(tsr_b[1]), 1);
      end
    end
    wr_en = 1'b0;
    clear_flags = 1'b1;
    cyc();
    clear_flags = 1'b0;
    check("t3_clear_a", int'(tsr_a[1]), 0);
    check("t3_clear_b", int'(tsr_b[1]), 0);
    clear_flags = 1'b1; wr_en = 1'b1;
    cyc();
    clear_flags = 1'b0; wr_en = 1'b0;
    check("t3_setwins_a", int'(tsr_a[1]), 1);
    check("t3_setwins_b", int'(tsr_b[1]), 1);
    clear_flags = 1'b1;
    cyc();
    clear_flags = 1'b0;
    wait_idle(20000, to);
    check("t3_drain", int'(to), 0);

    // Reset in the middle of the fourth data bit with bytes still queued
    align_tick();
    arm();
    burst = '{8'hC3, 8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = burst[i];
      cyc();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 2000 && ta < 72; i++) cyc();
    check("t4_reached", int'(ta >= 72), 1);
    check("t4_pre_tx", int'(tx_a), 0);
    #1 reset = 1'b0;
    #1;
    check("t4_tx_a", int'(tx_a), 1);
    check("t4_tx_b", int'(tx_b), 1);
    check("t4_tsr_a", int'(tsr_a), 9);
    check("t4_tsr_b", int'(tsr_b), 9);
    check("t4_full_a", int'(full_a), 0);
    repeat (3) cyc();
    reset = 1'b1;
    low = 0;
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (!tx_a || !tx_b) low++;
    end
    check("t4_quiet", low, 0);
    check("t4_tsr_after", int'(tsr_a), 9);

    // Randomised traffic with alternating light and overflowing write rates
    tick_mode = 1;
    for (int c = 0; c < 20000; c++) begin
      int rate;
      rate = (((c / 2500) % 2) != 0) ? 400 : 4;
      wr_en = ($urandom_range(999) < rate);
      wr_data = 8'($urandom);
      clear_flags = ($urandom_range(49) == 0);
      cyc();
    end
    wr_en = 1'b0;
    clear_flags = 1'b1;
    cyc();
    clear_flags = 1'b0;
    wait_idle(30000, to);
    check("rand_drain", int'(to), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
